instr_sequencer: RTL

//  Program-counter and control-flow stage that sits directly in front of the instruction ROM.
//  - Drives oInstructionAddress to the ROM every cycle.
//  - Takes back the combinational 28-bit instruction.
//  - Resolves JMP/CALL/RET and datapath branches (BLE/BGE) with a hardware return-address stack.
//  - Hands the current instruction to the decode/execute datapath.

---
 rtl/instr_sequencer_pkg.sv | 24 ++
 rtl/instr_sequencer_ret_addr_stack.sv | 45 ++++
 rtl/instr_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, address width and FSM states.
package instr_sequencer_pkg;

    localparam int unsigned AddrW = 16;
    localparam int unsigned InstrW = 28;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpJmp  = 4'd1,
        OpCall = 4'd2,
        OpRet  = 4'd3,
        OpBle  = 4'd4,
        OpBge  = 4'd5
    } opcode_e;

    // The only fault is a return-stack overflow/underflow, so one sticky state encodes it.
    typedef enum logic [0:0] {
        SeqRun   = 1'b0,
        SeqFault = 1'b1
    } seq_state_e;

    localparam logic [InstrW-1:0] NopInstr = {OpNop, 24'd0};

endpackage

// File: rtl/instr_sequencer_ret_addr_stack.sv
// Return-address LIFO. Only the occupancy counter is reset; entries above it are don't-care.
module instr_sequencer_ret_addr_stack #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] push_data_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [4:0]       level_o
);

    localparam int unsigned IdxW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [4:0]       level_q;
    logic [IdxW-1:0]  top_idx;

    assign full_o     = (level_q == 5'(Depth));
    assign empty_o    = (level_q == 5'd0);
    assign level_o    = level_q;
    assign top_idx    = level_q[IdxW-1:0] - IdxW'(1);
    assign pop_data_o = mem_q[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 5'd0;
        end else if (push_i && !full_o) begin
            level_q <= level_q + 5'd1;
        end else if (pop_i && !empty_o) begin
            level_q <= level_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[level_q[IdxW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program counter, next-PC selection and RUN/FAULT control in front of a combinational ROM.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned StackDepth = 8,
    parameter int unsigned AddrW      = instr_sequencer_pkg::AddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [27:0]       instruction_i,
    input  logic              branch_taken_i,
    input  logic              stall_i,
    output logic [AddrW-1:0]  instruction_address_o,
    output logic [27:0]       instruction_o,
    output logic              fault_o,
    output logic [4:0]        stack_level_o
);

    seq_state_e       state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d;
    logic [AddrW-1:0] pc_inc, target, pop_data;
    logic [3:0]       opcode;
    logic             push, pop, full, empty;

    assign opcode = instruction_i[27:24];
    assign target = AddrW'(instruction_i[23:16]);
    assign pc_inc = pc_q + AddrW'(1);

    instr_sequencer_ret_addr_stack #(
        .Depth (StackDepth),
        .Width (AddrW)
    ) u_ret_addr_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .pop_data_o  (pop_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (stack_level_o)
    );

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        // A stall simply suppresses the decision; the same instruction is re-decided next cycle.
        if (state_q == SeqRun && !stall_i) begin
            case (opcode)
                OpJmp: pc_d = target;
                OpCall: begin
                    if (full) begin
                        state_d = SeqFault;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                OpRet: begin
                    if (empty) begin
                        state_d = SeqFault;
                    end else begin
                        pop  = 1'b1;
                        pc_d = pop_data;
                    end
                end
                OpBle, OpBge: pc_d = branch_taken_i ? target : pc_inc;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            state_q <= SeqRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign instruction_address_o = pc_q;
    assign instruction_o         = (state_q == SeqFault) ? NopInstr : instruction_i;
    assign fault_o               = (state_q == SeqFault);

endmodule
